// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM state encoding and access direction.
// Latency: n/a (types only); backpressure: n/a.
package dm_arb_pkg;

    typedef enum logic {
        ST_CORE_PRI  = 1'b0,
        ST_DMA_BURST = 1'b1
    } arb_state_e;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

endpackage

// File: rtl/dm_arb_mux.sv
// Grant-selected mux of requester controls onto the memory port; idle cycles park on the core's values.
// Latency: combinational; backpressure: none, the grants come from the arbiter.
module dm_arb_mux #(
    parameter int ADR_SIZE  = 16,
    parameter int DATA_SIZE = 16
) (
    input  logic                 core_gnt,
    input  logic                 dma_gnt,
    input  logic                 core_wr_rd,
    input  logic [ADR_SIZE-1:0]  core_adr,
    input  logic [DATA_SIZE-1:0] core_dout,
    input  logic                 dma_wr_rd,
    input  logic [ADR_SIZE-1:0]  dma_adr,
    input  logic [DATA_SIZE-1:0] dma_dout,
    output logic                 mem_en,
    output logic                 mem_wr_rd,
    output logic [ADR_SIZE-1:0]  mem_adr,
    output logic [DATA_SIZE-1:0] mem_dout
);

    always_comb begin
        mem_en    = core_gnt | dma_gnt;
        mem_wr_rd = core_wr_rd;
        mem_adr   = core_adr;
        mem_dout  = core_dout;
        if (dma_gnt) begin
            mem_wr_rd = dma_wr_rd;
            mem_adr   = dma_adr;
            mem_dout  = dma_dout;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the data-memory port between core (fixed priority) and DMAC, with starvation-forced DMA bursts.
// Latency: grant same cycle, read valid one cycle later; backpressure: loser sees core_stall/dma_stall.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADR_SIZE   = 16,
    parameter int DATA_SIZE  = 16,
    parameter int STARVE_MAX = 4,
    parameter int BURST_LEN  = 4,
    parameter int CNT_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 core_en,
    input  logic                 core_wr_rd,
    input  logic [ADR_SIZE-1:0]  core_adr,
    input  logic [DATA_SIZE-1:0] core_dout,
    output logic [DATA_SIZE-1:0] core_din,
    output logic                 core_rvalid,
    output logic                 core_stall,
    input  logic                 dma_en,
    input  logic                 dma_wr_rd,
    input  logic [ADR_SIZE-1:0]  dma_adr,
    input  logic [DATA_SIZE-1:0] dma_dout,
    output logic [DATA_SIZE-1:0] dma_din,
    output logic                 dma_rvalid,
    output logic                 dma_stall,
    output logic                 mem_en,
    output logic                 mem_wr_rd,
    output logic [ADR_SIZE-1:0]  mem_adr,
    output logic [DATA_SIZE-1:0] mem_dout,
    input  logic [DATA_SIZE-1:0] mem_din
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             core_rvalid_q, core_rvalid_d;
    logic             dma_rvalid_q, dma_rvalid_d;
    logic             core_gnt, dma_gnt, force_dma;

    // No grant at all while rst is high, so both stalls follow their requests.
    always_comb begin
        force_dma = core_en & dma_en & (state_q == ST_CORE_PRI) & (starve_cnt_q == STARVE_LIM);
        dma_gnt   = ~rst & dma_en & (~core_en | (state_q == ST_DMA_BURST) | force_dma);
        core_gnt  = ~rst & core_en & ~dma_gnt;
    end

    assign core_stall  = core_en & ~core_gnt;
    assign dma_stall   = dma_en & ~dma_gnt;
    assign core_din    = mem_din;
    assign dma_din     = mem_din;
    assign core_rvalid = core_rvalid_q;
    assign dma_rvalid  = dma_rvalid_q;

    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        burst_cnt_d   = burst_cnt_q;
        core_rvalid_d = core_gnt & (core_wr_rd == RD);
        dma_rvalid_d  = dma_gnt & (dma_wr_rd == RD);

        if (dma_gnt) begin
            starve_cnt_d = '0;
        end else if (dma_en && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + CNT_ONE;
        end

        case (state_q)
            ST_CORE_PRI: begin
                // A one-grant burst is complete on the forcing grant itself.
                if (force_dma) begin
                    burst_cnt_d = CNT_ONE;
                    if (BURST_LIM != CNT_ONE) begin
                        state_d = ST_DMA_BURST;
                    end
                end
            end
            ST_DMA_BURST: begin
                if (!dma_en) begin
                    state_d = ST_CORE_PRI;
                end else if (dma_gnt) begin
                    burst_cnt_d = burst_cnt_q + CNT_ONE;
                    if ((burst_cnt_q + CNT_ONE) == BURST_LIM) begin
                        state_d = ST_CORE_PRI;
                    end
                end
            end
            default: state_d = ST_CORE_PRI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_CORE_PRI;
            starve_cnt_q  <= '0;
            burst_cnt_q   <= '0;
            core_rvalid_q <= 1'b0;
            dma_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            burst_cnt_q   <= burst_cnt_d;
            core_rvalid_q <= core_rvalid_d;
            dma_rvalid_q  <= dma_rvalid_d;
        end
    end

    dm_arb_mux #(
        .ADR_SIZE (ADR_SIZE),
        .DATA_SIZE(DATA_SIZE)
    ) u_mux (
        .core_gnt  (core_gnt),
        .dma_gnt   (dma_gnt),
        .core_wr_rd(core_wr_rd),
        .core_adr  (core_adr),
        .core_dout (core_dout),
        .dma_wr_rd (dma_wr_rd),
        .dma_adr   (dma_adr),
        .dma_dout  (dma_dout),
        .mem_en    (mem_en),
        .mem_wr_rd (mem_wr_rd),
        .mem_adr   (mem_adr),
        .mem_dout  (mem_dout)
    );

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: hand-derived vector table for the directed scenarios,
// then random traffic against a countdown-style reference model of the arbitration rules.
module tb_dm_port_arbiter;
    import dm_arb_pkg::*;

    localparam int SM = 4;
    localparam int BL = 4;
    localparam logic [15:0] CD = 16'hC0DE;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_en, core_wr_rd, core_rvalid, core_stall;
    logic [15:0] core_adr, core_dout, core_din;
    logic        dma_en, dma_wr_rd, dma_rvalid, dma_stall;
    logic [15:0] dma_adr, dma_dout, dma_din;
    logic        mem_en, mem_wr_rd;
    logic [15:0] mem_adr, mem_dout, mem_din;

    always #5 clk = ~clk;

    dm_port_arbiter #(
        .ADR_SIZE(16), .DATA_SIZE(16), .STARVE_MAX(SM), .BURST_LEN(BL), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .core_en(core_en), .core_wr_rd(core_wr_rd), .core_adr(core_adr), .core_dout(core_dout),
        .core_din(core_din), .core_rvalid(core_rvalid), .core_stall(core_stall),
        .dma_en(dma_en), .dma_wr_rd(dma_wr_rd), .dma_adr(dma_adr), .dma_dout(dma_dout),
        .dma_din(dma_din), .dma_rvalid(dma_rvalid), .dma_stall(dma_stall),
        .mem_en(mem_en), .mem_wr_rd(mem_wr_rd), .mem_adr(mem_adr), .mem_dout(mem_dout),
        .mem_din(mem_din)
    );

    typedef struct {
        logic        rst;
        logic        ce;
        logic        cw;
        logic [15:0] ca;
        logic        de;
        logic        dw;
        logic [15:0] da;
        logic [15:0] dd;
        logic        e_en;
        logic        e_dsel;
        logic        e_cs;
        logic        e_ds;
        logic        e_crv;
        logic        e_drv;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: remaining forced grants and denied-cycle count.
    int   m_starve = 0;
    int   m_burst_left = 0;
    logic m_crv = 1'b0;
    logic m_drv = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, ce, cw, input logic [15:0] ca,
                                input logic de, dw, input logic [15:0] da, dd,
                                input logic en, dsel, cs, ds, crv, drv);
        vec_t v;
        v.rst = r; v.ce = ce; v.cw = cw; v.ca = ca;
        v.de = de; v.dw = dw; v.da = da; v.dd = dd;
        v.e_en = en; v.e_dsel = dsel; v.e_cs = cs; v.e_ds = ds;
        v.e_crv = crv; v.e_drv = drv;
        return v;
    endfunction

    task automatic apply(input logic r, ce, cw, input logic [15:0] ca, cd,
                         input logic de, dw, input logic [15:0] da, dd, md);
        rst = r; core_en = ce; core_wr_rd = cw; core_adr = ca; core_dout = cd;
        dma_en = de; dma_wr_rd = dw; dma_adr = da; dma_dout = dd; mem_din = md;
    endtask

    function automatic logic exp_dma_gnt();
        return !rst && dma_en && (!core_en || m_burst_left > 0 || m_starve == SM);
    endfunction

    function automatic logic exp_core_gnt();
        return !rst && core_en && !exp_dma_gnt();
    endfunction

    task automatic model_update();
        logic gd, gc;
        gd = exp_dma_gnt();
        gc = exp_core_gnt();
        if (rst) begin
            m_starve = 0; m_burst_left = 0; m_crv = 1'b0; m_drv = 1'b0;
        end else begin
            m_crv = gc && (core_wr_rd == RD);
            m_drv = gd && (dma_wr_rd == RD);
            if (gd) begin
                if (m_burst_left > 0) m_burst_left--;
                else if (core_en) m_burst_left = BL - 1;
                m_starve = 0;
            end else if (dma_en && m_starve < SM) begin
                m_starve++;
            end
            if (!dma_en) m_burst_left = 0;
        end
    endtask

    task automatic check_model();
        logic gd, gc;
        gd = exp_dma_gnt();
        gc = exp_core_gnt();
        chk("rnd mem_en", 32'(mem_en), 32'(gd | gc));
        chk("rnd mem_adr", 32'(mem_adr), 32'(gd ? dma_adr : core_adr));
        chk("rnd mem_wr_rd", 32'(mem_wr_rd), 32'(gd ? dma_wr_rd : core_wr_rd));
        chk("rnd mem_dout", 32'(mem_dout), 32'(gd ? dma_dout : core_dout));
        chk("rnd core_stall", 32'(core_stall), 32'(core_en & ~gc));
        chk("rnd dma_stall", 32'(dma_stall), 32'(dma_en & ~gd));
        chk("rnd core_rvalid", 32'(core_rvalid), 32'(m_crv));
        chk("rnd dma_rvalid", 32'(dma_rvalid), 32'(m_drv));
        chk("rnd din", 32'({core_din, dma_din}), {mem_din, mem_din});
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        logic [15:0] md;

        tbl.push_back(mk(1, 1,0,16'h0010, 1,0,16'h0100,16'hBEEF, 0,0,1,1,0,0));
        tbl.push_back(mk(0, 1,0,16'h0010, 0,0,16'h0100,16'hBEEF, 1,0,0,0,0,0));
        tbl.push_back(mk(0, 0,1,16'h0020, 0,0,16'h0100,16'hBEEF, 0,0,0,0,1,0));
        tbl.push_back(mk(0, 0,1,16'h0020, 1,1,16'h0100,16'hBEEF, 1,1,0,0,0,0));
        tbl.push_back(mk(0, 0,1,16'h0020, 0,0,16'h0100,16'hBEEF, 0,0,0,0,0,0));
        // Continuous contention: 4 core, 4 forced DMA, then core again.
        tbl.push_back(mk(0, 1,0,16'h0010, 1,0,16'h0100,16'hBEEF, 1,0,0,1,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 1,0,16'h0010, 1,0,16'h0100,16'hBEEF, 1,0,0,1,1,0));
        tbl.push_back(mk(0, 1,0,16'h0010, 1,0,16'h0100,16'hBEEF, 1,1,1,0,1,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 1,0,16'h0010, 1,0,16'h0100,16'hBEEF, 1,1,1,0,0,1));
        tbl.push_back(mk(0, 1,0,16'h0010, 1,0,16'h0100,16'hBEEF, 1,0,0,1,0,1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 1,0,16'h0010, 1,0,16'h0100,16'hBEEF, 1,0,0,1,1,0));
        // Burst abandoned after two grants.
        tbl.push_back(mk(0, 1,0,16'h0010, 1,0,16'h0100,16'hBEEF, 1,1,1,0,1,0));
        tbl.push_back(mk(0, 1,0,16'h0010, 1,0,16'h0100,16'hBEEF, 1,1,1,0,0,1));
        tbl.push_back(mk(0, 1,0,16'h0010, 0,0,16'h0100,16'hBEEF, 1,0,0,0,0,1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1,0,16'h0010, 1,0,16'h0100,16'hBEEF, 1,0,0,1,1,0));
        // Reset mid-burst with a DMA read outstanding.
        tbl.push_back(mk(0, 1,0,16'h0010, 1,0,16'h0100,16'hBEEF, 1,1,1,0,1,0));
        tbl.push_back(mk(1, 1,0,16'h0010, 1,0,16'h0100,16'hBEEF, 0,0,1,1,0,1));
        tbl.push_back(mk(0, 1,0,16'h0010, 1,0,16'h0100,16'hBEEF, 1,0,0,1,0,0));
        // Alternating uncontended reads.
        tbl.push_back(mk(0, 1,0,16'h0030, 0,0,16'h0140,16'h1234, 1,0,0,0,1,0));
        tbl.push_back(mk(0, 0,0,16'h0030, 1,0,16'h0140,16'h1234, 1,1,0,0,1,0));
        tbl.push_back(mk(0, 1,0,16'h0030, 0,0,16'h0140,16'h1234, 1,0,0,0,0,1));
        tbl.push_back(mk(0, 0,0,16'h0030, 1,0,16'h0140,16'h1234, 1,1,0,0,1,0));
        tbl.push_back(mk(0, 0,0,16'h0030, 0,0,16'h0140,16'h1234, 0,0,0,0,0,1));
        tbl.push_back(mk(0, 0,0,16'h0030, 0,0,16'h0140,16'h1234, 0,0,0,0,0,0));

        apply(1, 0, 0, 16'h0, CD, 0, 0, 16'h0, 16'h0, 16'h0);
        model_update();
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            v = tbl[i];
            md = 16'($urandom);
            apply(v.rst, v.ce, v.cw, v.ca, CD, v.de, v.dw, v.da, v.dd, md);
            #4;
            chk("tbl mem_en", 32'(mem_en), 32'(v.e_en));
            chk("tbl mem_adr", 32'(mem_adr), 32'(v.e_dsel ? v.da : v.ca));
            chk("tbl mem_wr_rd", 32'(mem_wr_rd), 32'(v.e_dsel ? v.dw : v.cw));
            chk("tbl mem_dout", 32'(mem_dout), 32'(v.e_dsel ? v.dd : CD));
            chk("tbl core_stall", 32'(core_stall), 32'(v.e_cs));
            chk("tbl dma_stall", 32'(dma_stall), 32'(v.e_ds));
            chk("tbl core_rvalid", 32'(core_rvalid), 32'(v.e_crv));
            chk("tbl dma_rvalid", 32'(dma_rvalid), 32'(v.e_drv));
            chk("tbl din", 32'({core_din, dma_din}), {md, md});
            model_update();
            @(posedge clk); #1;
        end

        apply(1, 0, 0, 16'h0, CD, 0, 0, 16'h0, 16'h0, 16'h0);
        model_update();
        @(posedge clk); #1;

        for (int c = 0; c < 3000; c++) begin
            apply($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom));
            #4;
            check_model();
            model_update();
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
